// File: rtl/detect_scheduler.sv
// Round-robin scheduler sharing one serial 1-bit-count detector among NUM_REQ requesters.
// Session: CLEAR (1 cycle), RUN (one bit per cycle), REPORT (1-cycle Done pulse); all outputs registered.
module detect_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int THRESHOLD = 3,
    parameter int MAX_BITS  = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NUM_REQ-1:0] Req,
    input  logic [NUM_REQ-1:0] Data,
    output logic [NUM_REQ-1:0] Grant,
    output logic               Busy,
    output logic               Done,
    output logic               Hit,
    output logic               Aborted,
    output logic [ID_W-1:0]    Done_Id
);

    localparam int ONES_W = $clog2(THRESHOLD + 1);
    localparam int BITS_W = $clog2(MAX_BITS + 1);
    localparam logic [ONES_W-1:0] THR_C    = ONES_W'(THRESHOLD);
    localparam logic [BITS_W-1:0] MAX_C    = BITS_W'(MAX_BITS);
    localparam logic [ID_W-1:0]   LAST_RST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, REPORT} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     winner_q, winner_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [BITS_W-1:0]   bits_q, bits_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hit_q, hit_d;
    logic                aborted_q, aborted_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic                found;
    logic [ID_W-1:0]     cand;
    int                  idx;

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        last_d    = last_q;
        ones_d    = ones_q;
        bits_d    = bits_q;
        hit_d     = 1'b0;
        aborted_d = 1'b0;
        found     = 1'b0;
        cand      = '0;
        idx       = 0;

        case (state_q)
            IDLE: begin
                if (|Req) begin
                    // Scan starts one past the previous winner so every requester gets a turn.
                    for (int i = 0; i < NUM_REQ; i++) begin
                        idx = int'(last_q) + 1 + i;
                        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                        cand = ID_W'(idx);
                        if (!found && Req[cand]) begin
                            found    = 1'b1;
                            winner_d = cand;
                        end
                    end
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                ones_d  = '0;
                bits_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                // A dropped request ends the session before this cycle's bit is counted.
                if (!Req[winner_q]) begin
                    aborted_d = 1'b1;
                    state_d   = REPORT;
                end else begin
                    bits_d = bits_q + BITS_W'(1);
                    if (Data[winner_q] && ones_q != THR_C) ones_d = ones_q + ONES_W'(1);
                    if (ones_d == THR_C) begin
                        hit_d   = 1'b1;
                        state_d = REPORT;
                    end else if (bits_d == MAX_C) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                last_d  = winner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == REPORT);
        grant_d   = (state_d == CLEAR || state_d == RUN) ? (NUM_REQ'(1) << winner_d) : '0;
        done_id_d = done_d ? winner_d : '0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            winner_q  <= '0;
            last_q    <= LAST_RST;
            ones_q    <= '0;
            bits_q    <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            aborted_q <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            last_q    <= last_d;
            ones_q    <= ones_d;
            bits_q    <= bits_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hit_q     <= hit_d;
            aborted_q <= aborted_d;
            done_id_q <= done_id_d;
        end
    end

    assign Grant   = grant_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Hit     = hit_q;
    assign Aborted = aborted_q;
    assign Done_Id = done_id_q;

endmodule

// File: tb/tb_detect_scheduler.sv
// Bench for detect_scheduler: directed scenarios plus randomized sessions against a session-level model.
module tb_detect_scheduler;

    localparam int N    = 4;
    localparam int THR  = 3;
    localparam int MAXB = 16;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [3:0] Req = 4'b0;
    logic [3:0] Data = 4'b0;
    logic [3:0] Grant;
    logic       Busy, Done, Hit, Aborted;
    logic [1:0] Done_Id;

    detect_scheduler #(
        .NUM_REQ(N), .ID_W(2), .THRESHOLD(THR), .MAX_BITS(MAXB)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Data(Data), .Grant(Grant), .Busy(Busy),
        .Done(Done), .Hit(Hit), .Aborted(Aborted), .Done_Id(Done_Id)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Model state and per-session expectations
    int          model_last = N - 1;
    logic [15:0] bits_arr [4];
    int          exp_w, exp_n;
    logic        exp_hit, exp_abort;
    logic [3:0]  exp_grant;

    // Per-session observations
    logic [3:0]  obs_first_grant, obs_rep_grant, obs_idle_grant;
    int          obs_done_c, obs_grant_cycles;
    logic        obs_hit, obs_abort, obs_rep_busy, obs_idle_busy, obs_idle_done;
    logic        obs_leak, obs_grant_bad;
    logic [1:0]  obs_id;
    logic [3:0]  obs_idle_flags;

    // Called #1 after an edge with the DUT idle; returns #1 after the idle cycle following REPORT.
    task automatic run_session(input logic [3:0] mask, input int abort_at, input bit jitter);
        int idx, ones, k;
        logic [3:0] d;
        logic dropped;
        exp_w = -1;
        for (int i = 0; i < N; i++) begin
            idx = (model_last + 1 + i) % N;
            if (exp_w < 0 && mask[idx]) exp_w = idx;
        end
        exp_hit = 1'b0; exp_abort = 1'b0; exp_n = MAXB; ones = 0;
        for (int b = 0; b < MAXB; b++) begin
            if (b == abort_at) begin exp_abort = 1'b1; exp_n = b + 1; break; end
            if (bits_arr[exp_w][b]) ones++;
            if (ones == THR) begin exp_hit = 1'b1; exp_n = b + 1; break; end
        end
        model_last = exp_w;
        exp_grant = 4'(1 << exp_w);

        Req = mask; Data = 4'($urandom);
        obs_done_c = -1; obs_grant_cycles = 0; obs_leak = 1'b0; obs_grant_bad = 1'b0;
        obs_hit = 1'bx; obs_abort = 1'bx; obs_id = 2'bxx; obs_rep_grant = 4'bx; obs_rep_busy = 1'bx;
        dropped = 1'b0;
        @(posedge Clk); #1;
        obs_first_grant = Grant;
        for (int c = 0; c < 40; c++) begin
            if (Done === 1'b1) begin
                obs_done_c = c; obs_hit = Hit; obs_abort = Aborted; obs_id = Done_Id;
                obs_rep_grant = Grant; obs_rep_busy = Busy;
                break;
            end
            if (Grant !== 4'b0000) obs_grant_cycles++;
            if (Grant !== obs_first_grant || Busy !== 1'b1) obs_grant_bad = 1'b1;
            if (Hit !== 1'b0 || Aborted !== 1'b0 || Done_Id !== 2'b00) obs_leak = 1'b1;
            d = 4'($urandom);
            if (c >= 1) begin
                k = c - 1;
                for (int r = 0; r < N; r++) d[r] = (k < MAXB) ? bits_arr[r][k] : 1'b0;
                if (k == abort_at) dropped = 1'b1;
            end
            Req = (jitter ? (4'($urandom) & ~exp_grant) : (mask & ~exp_grant)) | (dropped ? 4'b0 : exp_grant);
            Data = d;
            @(posedge Clk); #1;
        end
        Req = mask;
        @(posedge Clk); #1;
        obs_idle_grant = Grant; obs_idle_busy = Busy; obs_idle_done = Done;
        obs_idle_flags = {Hit, Aborted, Done_Id};
    endtask

    task automatic apply_reset();
        Req = 4'b0; Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; model_last = N - 1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Req = 4'hF; Data = 4'hF;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (Grant !== 4'b0)   begin errors++; $display("FAIL reset_grant got %b exp 0000", Grant); end
        checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        checks++; if (Done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", Done); end
        checks++; if (Hit !== 1'b0)     begin errors++; $display("FAIL reset_hit got %b exp 0", Hit); end
        checks++; if (Aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got %b exp 0", Aborted); end
        checks++; if (Done_Id !== 2'b0) begin errors++; $display("FAIL reset_done_id got %0d exp 0", Done_Id); end
        Rst = 1'b0; Req = 4'b0; model_last = N - 1;
    endtask

    task automatic test_idle();
        Req = 4'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            checks++; if ({Grant, Busy} !== 5'b0) begin errors++; $display("FAIL idle_quiet cycle %0d got grant %b busy %b exp 0000/0", i, Grant, Busy); end
        end
    endtask

    task automatic test_hit_min_latency();
        bits_arr[0] = 16'hFFFF; bits_arr[1] = 16'($urandom); bits_arr[2] = 16'($urandom); bits_arr[3] = 16'($urandom);
        run_session(4'b0001, -1, 1'b0);
        checks++; if (obs_first_grant !== 4'b0001) begin errors++; $display("FAIL hit_grant got %b exp 0001", obs_first_grant); end
        checks++; if (obs_grant_cycles != 4) begin errors++; $display("FAIL hit_grant_cycles got %0d exp 4", obs_grant_cycles); end
        checks++; if (obs_done_c != THR + 1) begin errors++; $display("FAIL hit_done_time got %0d exp %0d", obs_done_c, THR + 1); end
        checks++; if ({obs_hit, obs_abort, obs_id} !== 4'b1000) begin errors++; $display("FAIL hit_result got hit %b abort %b id %0d exp 1 0 0", obs_hit, obs_abort, obs_id); end
        checks++; if (obs_rep_grant !== 4'b0) begin errors++; $display("FAIL hit_report_grant got %b exp 0000", obs_rep_grant); end
    endtask

    task automatic test_max_bits();
        bits_arr[1] = 16'h0000;
        run_session(4'b0010, -1, 1'b0);
        checks++; if (obs_first_grant !== 4'b0010) begin errors++; $display("FAIL max_grant got %b exp 0010", obs_first_grant); end
        checks++; if (obs_done_c != MAXB + 1) begin errors++; $display("FAIL max_done_time got %0d exp %0d", obs_done_c, MAXB + 1); end
        checks++; if ({obs_hit, obs_abort, obs_id} !== 4'b0001) begin errors++; $display("FAIL max_result got hit %b abort %b id %0d exp 0 0 1", obs_hit, obs_abort, obs_id); end
        checks++; if ({obs_idle_busy, obs_idle_done} !== 2'b00) begin errors++; $display("FAIL max_idle got busy %b done %b exp 0 0", obs_idle_busy, obs_idle_done); end
    endtask

    task automatic test_round_robin();
        logic [3:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int r = 0; r < N; r++) bits_arr[r] = 16'hFFFF;
        apply_reset();
        for (int s = 0; s < 5; s++) begin
            run_session(4'b1111, -1, 1'b0);
            checks++; if (obs_first_grant !== rr_exp[s]) begin errors++; $display("FAIL rr_grant session %0d got %b exp %b", s, obs_first_grant, rr_exp[s]); end
            checks++; if (obs_done_c != THR + 1) begin errors++; $display("FAIL rr_done_time session %0d got %0d exp %0d", s, obs_done_c, THR + 1); end
        end
    endtask

    task automatic test_abort();
        bits_arr[2] = 16'hFFFF;
        run_session(4'b0100, 1, 1'b0);
        checks++; if (obs_done_c != 3) begin errors++; $display("FAIL abort_done_time got %0d exp 3", obs_done_c); end
        checks++; if ({obs_hit, obs_abort, obs_id} !== 4'b0110) begin errors++; $display("FAIL abort_result got hit %b abort %b id %0d exp 0 1 2", obs_hit, obs_abort, obs_id); end
    endtask

    task automatic test_abort_vs_hit();
        bits_arr[2] = 16'hFFFF;
        run_session(4'b0100, 2, 1'b0);
        checks++; if (obs_done_c != 4) begin errors++; $display("FAIL abort_hit_done_time got %0d exp 4", obs_done_c); end
        checks++; if ({obs_hit, obs_abort} !== 2'b01) begin errors++; $display("FAIL abort_hit_result got hit %b abort %b exp 0 1", obs_hit, obs_abort); end
    endtask

    task automatic test_hit_vs_max();
        bits_arr[3] = 16'hE000;
        run_session(4'b1000, -1, 1'b0);
        checks++; if (obs_done_c != MAXB + 1) begin errors++; $display("FAIL hit_max_done_time got %0d exp %0d", obs_done_c, MAXB + 1); end
        checks++; if ({obs_hit, obs_abort, obs_id} !== 4'b1011) begin errors++; $display("FAIL hit_max_result got hit %b abort %b id %0d exp 1 0 3", obs_hit, obs_abort, obs_id); end
    endtask

    task automatic test_reset_mid_run();
        Req = 4'b0100; Data = 4'b0;
        repeat (4) @(posedge Clk);
        #1;
        checks++; if (Grant !== 4'b0100) begin errors++; $display("FAIL midrst_running got %b exp 0100", Grant); end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; model_last = N - 1;
        checks++; if ({Grant, Busy, Done} !== 6'b0) begin errors++; $display("FAIL midrst_cleared got grant %b busy %b done %b exp 0000 0 0", Grant, Busy, Done); end
        for (int r = 0; r < N; r++) bits_arr[r] = 16'hFFFF;
        run_session(4'b1111, -1, 1'b0);
        checks++; if (obs_first_grant !== 4'b0001) begin errors++; $display("FAIL midrst_next_grant got %b exp 0001", obs_first_grant); end
        checks++; if (obs_id !== 2'd0) begin errors++; $display("FAIL midrst_next_id got %0d exp 0", obs_id); end
    endtask

    task automatic test_random();
        logic [3:0] mask;
        int ab;
        for (int it = 0; it < 40; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int r = 0; r < N; r++)
                bits_arr[r] = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXB - 1)) : -1;
            run_session(mask, ab, 1'b1);
            checks++; if (obs_first_grant !== exp_grant) begin errors++; $display("FAIL rnd_grant it %0d got %b exp %b", it, obs_first_grant, exp_grant); end
            checks++; if (obs_done_c != exp_n + 1) begin errors++; $display("FAIL rnd_done_time it %0d got %0d exp %0d", it, obs_done_c, exp_n + 1); end
            checks++; if (obs_grant_cycles != exp_n + 1) begin errors++; $display("FAIL rnd_grant_cycles it %0d got %0d exp %0d", it, obs_grant_cycles, exp_n + 1); end
            checks++; if (obs_hit !== exp_hit) begin errors++; $display("FAIL rnd_hit it %0d got %b exp %b", it, obs_hit, exp_hit); end
            checks++; if (obs_abort !== exp_abort) begin errors++; $display("FAIL rnd_abort it %0d got %b exp %b", it, obs_abort, exp_abort); end
            checks++; if (obs_id !== 2'(exp_w)) begin errors++; $display("FAIL rnd_done_id it %0d got %0d exp %0d", it, obs_id, exp_w); end
            checks++; if ({obs_rep_grant, obs_rep_busy} !== 5'b00001) begin errors++; $display("FAIL rnd_report it %0d got grant %b busy %b exp 0000 1", it, obs_rep_grant, obs_rep_busy); end
            checks++; if ({obs_idle_grant, obs_idle_busy, obs_idle_done, obs_idle_flags} !== 10'b0) begin errors++; $display("FAIL rnd_idle it %0d got grant %b busy %b done %b flags %b exp zeros", it, obs_idle_grant, obs_idle_busy, obs_idle_done, obs_idle_flags); end
            checks++; if ({obs_leak, obs_grant_bad} !== 2'b00) begin errors++; $display("FAIL rnd_session_stable it %0d got leak %b grant_bad %b exp 0 0", it, obs_leak, obs_grant_bad); end
        end
        Req = 4'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_hit_min_latency();
        test_max_bits();
        test_round_robin();
        test_abort();
        test_abort_vs_hit();
        test_hit_vs_max();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
